// File: rtl/blit_pkg.sv
// Shared geometry, screen widths and FSM state
// encoding for the ring sprite blitter.
package blit_pkg;

  localparam int ROWS   = 66;
  localparam int COLS   = 59;
  localparam int ADDR_W = 7;
  localparam int X_W    = 10;
  localparam int Y_W    = 10;
  localparam int COL_W  = $clog2(COLS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EMIT,
    FINISH
  } state_t;

endpackage

// File: rtl/sprite_row_shifter.sv
// Holds one sprite row, presents the leftmost pixel
// and flags when the last column is on the output.
module sprite_row_shifter
  import blit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            advance,
  input  logic [COLS-1:0] row_bits,
  output logic            bit_out,
  output logic            last
);

  logic [COLS-1:0]  sr;
  logic [COL_W-1:0] col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      col <= '0;
    end else if (load) begin
      sr  <= row_bits;
      col <= '0;
    end else if (advance) begin
      sr  <= {sr[COLS-2:0], 1'b0};
      col <= col + 1'b1;
    end
  end

  assign bit_out = sr[COLS-1];
  assign last    = (col == COL_W'(COLS - 1));

endmodule

// File: rtl/sprite_blitter.sv
// Streams a ROM-resident sprite to the framebuffer
// one pixel per valid/ready handshake.
module sprite_blitter
  import blit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [X_W-1:0]    start_x,
  input  logic [Y_W-1:0]    start_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [COLS-1:0]   rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [X_W-1:0]    pix_x,
  output logic [Y_W-1:0]    pix_y,
  output logic              pix_on
);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] row;
  logic [X_W-1:0]    base_x;
  logic [Y_W-1:0]    base_y;
  logic              load, advance;
  logic              last_col, last_row;
  logic              xfer, accept, row_end;

  assign xfer     = pix_valid & pix_ready;
  assign accept   = (state == IDLE) & start;
  assign last_row = (row == ADDR_W'(ROWS - 1));
  assign row_end  = (state == EMIT) & xfer & last_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        busy      = 1'b1;
        state_nxt = LOAD;
      end
      LOAD: begin
        busy      = 1'b1;
        load      = 1'b1;
        state_nxt = EMIT;
      end
      EMIT: begin
        busy = 1'b1;
        if (xfer) begin
          if (!last_col)     advance   = 1'b1;
          else if (last_row) state_nxt = FINISH;
          else               state_nxt = FETCH;
        end
      end
      FINISH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is set on entry to FETCH so a
  // registered ROM has its row ready for LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      base_x    <= '0;
      base_y    <= '0;
      rom_addr  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
    end else begin
      if (accept) begin
        base_x   <= start_x;
        base_y   <= start_y;
        row      <= '0;
        rom_addr <= '0;
      end
      if (load) begin
        pix_x     <= base_x;
        pix_y     <= base_y + Y_W'(row);
        pix_valid <= 1'b1;
      end
      if (advance) pix_x <= pix_x + 1'b1;
      if (row_end) begin
        pix_valid <= 1'b0;
        if (!last_row) begin
          row      <= row + 1'b1;
          rom_addr <= row + 1'b1;
        end
      end
    end
  end

  sprite_row_shifter u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .advance  (advance),
    .row_bits (rom_data),
    .bit_out  (pix_on),
    .last     (last_col)
  );

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a ring
// sprite ROM and a pixel-stream reference model.
module tb_sprite_blitter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  start_x = '0;
  logic [9:0]  start_y = '0;
  logic        busy, done;
  logic [6:0]  rom_addr;
  logic [58:0] rom_data = '0;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [9:0]  pix_x, pix_y;
  logic        pix_on;

  int n_checks = 0;
  int n_pass   = 0;

  sprite_blitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_x   (start_x),
    .start_y   (start_y),
    .busy      (busy),
    .done      (done),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_on    (pix_on)
  );

  always #5 clk = ~clk;

  // Ring: rounded caps 7 px wide, 2 px walls.
  function automatic bit ring_on(int r, int c);
    int d, rr, ho;
    d  = (c > 29) ? c - 29 : 29 - c;
    rr = (r < 33) ? r : 65 - r;
    ho = (rr >= 17) ? 29 : 3 + (26 * rr) / 17;
    return (d <= ho) && (d >= ho - 1 || rr == 0);
  endfunction

  logic [58:0] rom [0:65];

  initial begin
    for (int r = 0; r < 66; r++)
      for (int c = 0; c < 59; c++)
        rom[r][58-c] = ring_on(r, c);
  end

  always @(posedge clk)
    rom_data <= (rom_addr < 7'd66) ? rom[rom_addr] : '0;

  int           n_xfer, n_bad, n_stab, n_done;
  int           done_cyc, first_bad;
  bit           timed_out, aborted;
  logic         busy_c1, idle_busy;
  logic [6:0]   fetch_addr;
  logic [255:0] map0, map17;
  logic [9:0]   y4;
  logic [127:0] addr_seen;
  logic [30:0]  snap;

  task automatic run_blit(
    input logic [9:0] sx,
    input logic [9:0] sy,
    input bit         rnd,
    input int         inj,
    input bit         fin_start,
    input int         abort_k
  );
    int cyc, k, r, c;
    logic [9:0] px, py, ex, ey;
    logic pon, eon;
    bit hold;
    n_xfer = 0; n_bad = 0; n_stab = 0; n_done = 0;
    done_cyc = 0; first_bad = -1;
    timed_out = 0; aborted = 0;
    map0 = '0; map17 = '0; y4 = '1;
    addr_seen = '0; idle_busy = 1'bx;
    busy_c1 = 1'b0; fetch_addr = '1;
    start = 1'b1; start_x = sx; start_y = sy;
    cyc = 0; k = 0; hold = 0;
    px = '0; py = '0; pon = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        timed_out = 1;
        break;
      end
      if (cyc == 1) begin
        start = 1'b0;
        busy_c1 = busy;
        fetch_addr = rom_addr;
        start_x = '0;
        start_y = '0;
      end
      if (cyc == inj) begin
        start = 1'b1;
        start_x = 10'd5;
        start_y = 10'd5;
      end else if (inj > 0 && cyc == inj + 1) begin
        start = 1'b0;
      end
      if (n_done > 0 && cyc == done_cyc + 1) begin
        if (fin_start) begin
          start = 1'b0;
          idle_busy = busy;
        end
        break;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (busy) addr_seen[rom_addr] = 1'b1;
      if (hold && (pix_x !== px || pix_y !== py ||
                   pix_on !== pon || pix_valid !== 1'b1))
        n_stab++;
      if (pix_valid && pix_ready) begin
        if (k == abort_k) begin
          rst_n = 1'b0;
          #1;
          snap = {busy, done, pix_valid, pix_on,
                  rom_addr, pix_x, pix_y};
          aborted = 1;
          break;
        end
        r = k / 59;
        c = k % 59;
        ex = sx + 10'(c);
        ey = sy + 10'(r);
        eon = ring_on(r, c);
        if (pix_x !== ex || pix_y !== ey || pix_on !== eon) begin
          n_bad++;
          if (first_bad < 0) first_bad = k;
        end
        if (r == 0 && pix_on === 1'b1 && pix_x < 10'd256)
          map0[pix_x[7:0]] = 1'b1;
        if (r == 17 && pix_on === 1'b1 && pix_x < 10'd256)
          map17[pix_x[7:0]] = 1'b1;
        if (r == 4 && c == 0) y4 = pix_y;
        k++;
        n_xfer++;
      end
      hold = pix_valid && !pix_ready;
      px = pix_x; py = pix_y; pon = pix_on;
      if (done) begin
        n_done++;
        done_cyc = cyc;
        if (fin_start) begin
          start = 1'b1;
          start_x = 10'd7;
          start_y = 10'd7;
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, pix_valid, pix_on} !== 4'b0)
      $display("FAIL reset_flags got=%b want=0000",
               {busy, done, pix_valid, pix_on});
    else n_pass++;
    n_checks++;
    if ({rom_addr, pix_x, pix_y} !== 27'd0)
      $display("FAIL reset_regs got=%h/%0d/%0d want=0/0/0",
               rom_addr, pix_x, pix_y);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_blit();
    logic [255:0] e0, e17;
    logic [127:0] ea;
    e0 = '0; e17 = '0; ea = '0;
    for (int x = 126; x <= 132; x++) e0[x] = 1'b1;
    e17[100] = 1'b1; e17[101] = 1'b1;
    e17[157] = 1'b1; e17[158] = 1'b1;
    for (int a = 0; a < 66; a++) ea[a] = 1'b1;
    run_blit(10'd100, 10'd20, 0, 0, 0, -1);
    n_checks++;
    if (timed_out) $display("FAIL full_timeout got=1 want=0");
    else n_pass++;
    n_checks++;
    if (busy_c1 !== 1'b1)
      $display("FAIL full_busy got=%b want=1", busy_c1);
    else n_pass++;
    n_checks++;
    if (n_xfer != 3894)
      $display("FAIL full_xfers got=%0d want=3894", n_xfer);
    else n_pass++;
    n_checks++;
    if (n_bad != 0)
      $display("FAIL full_pixels bad=%0d first=%0d want=0",
               n_bad, first_bad);
    else n_pass++;
    n_checks++;
    if (n_done != 1 || done_cyc != 4027)
      $display("FAIL full_done got=%0d@%0d want=1@4027",
               n_done, done_cyc);
    else n_pass++;
    n_checks++;
    if (map0 !== e0)
      $display("FAIL full_row0 got=%h want=%h", map0, e0);
    else n_pass++;
    n_checks++;
    if (map17 !== e17)
      $display("FAIL full_row17 got=%h want=%h", map17, e17);
    else n_pass++;
    n_checks++;
    if (addr_seen !== ea)
      $display("FAIL full_addr got=%h want=%h", addr_seen, ea);
    else n_pass++;
  endtask

  task automatic test_random_ready();
    run_blit(10'd100, 10'd20, 1, 0, 0, -1);
    pix_ready = 1'b1;
    n_checks++;
    if (timed_out || n_xfer != 3894)
      $display("FAIL rnd_xfers got=%0d to=%0d want=3894",
               n_xfer, timed_out);
    else n_pass++;
    n_checks++;
    if (n_bad != 0)
      $display("FAIL rnd_pixels bad=%0d first=%0d want=0",
               n_bad, first_bad);
    else n_pass++;
    n_checks++;
    if (n_stab != 0)
      $display("FAIL rnd_stable got=%0d want=0", n_stab);
    else n_pass++;
    n_checks++;
    if (n_done != 1)
      $display("FAIL rnd_done got=%0d want=1", n_done);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [255:0] e0;
    e0 = '0;
    for (int x = 2; x <= 8; x++) e0[x] = 1'b1;
    run_blit(10'd1000, 10'd1020, 0, 0, 0, -1);
    n_checks++;
    if (map0 !== e0)
      $display("FAIL wrap_row0 got=%h want=%h", map0, e0);
    else n_pass++;
    n_checks++;
    if (y4 !== 10'd0)
      $display("FAIL wrap_row4_y got=%0d want=0", y4);
    else n_pass++;
    n_checks++;
    if (n_bad != 0 || n_xfer != 3894)
      $display("FAIL wrap_pixels bad=%0d n=%0d want=0/3894",
               n_bad, n_xfer);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    run_blit(10'd100, 10'd20, 0, 300, 1, -1);
    n_checks++;
    if (n_bad != 0 || n_xfer != 3894)
      $display("FAIL inj_pixels bad=%0d n=%0d want=0/3894",
               n_bad, n_xfer);
    else n_pass++;
    n_checks++;
    if (n_done != 1)
      $display("FAIL inj_done got=%0d want=1", n_done);
    else n_pass++;
    n_checks++;
    if (idle_busy !== 1'b0)
      $display("FAIL finish_start got=%b want=0", idle_busy);
    else n_pass++;
    run_blit(10'd40, 10'd60, 0, 0, 0, -1);
    n_checks++;
    if (busy_c1 !== 1'b1)
      $display("FAIL after_done_busy got=%b want=1", busy_c1);
    else n_pass++;
    n_checks++;
    if (n_bad != 0 || n_done != 1)
      $display("FAIL after_done_blit bad=%0d done=%0d want=0/1",
               n_bad, n_done);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int dn;
    run_blit(10'd100, 10'd20, 0, 0, 0, 30 * 59 + 10);
    n_checks++;
    if (!aborted)
      $display("FAIL abort_reached got=0 want=1");
    else n_pass++;
    n_checks++;
    if (snap !== 31'd0)
      $display("FAIL abort_outputs got=%h want=0", snap);
    else n_pass++;
    dn = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done) dn++;
    n_checks++;
    if (dn != 0)
      $display("FAIL abort_done got=%0d want=0", dn);
    else n_pass++;
    run_blit(10'd300, 10'd200, 0, 0, 0, -1);
    n_checks++;
    if (fetch_addr !== 7'd0)
      $display("FAIL restart_addr got=%0d want=0", fetch_addr);
    else n_pass++;
    n_checks++;
    if (n_bad != 0 || n_xfer != 3894 || n_done != 1)
      $display("FAIL restart_blit bad=%0d n=%0d d=%0d want=0/3894/1",
               n_bad, n_xfer, n_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dones, bad_n, bad_a, bad_b;
    logic [127:0] ea;
    ea = '0;
    for (int a = 0; a < 66; a++) ea[a] = 1'b1;
    dones = 0; bad_n = 0; bad_a = 0; bad_b = 0;
    for (int b = 0; b < 3; b++) begin
      run_blit(10'(17 * b), 10'(33 * b), 0, 0, 0, -1);
      dones += n_done;
      if (n_xfer != 3894 || n_bad != 0) bad_n++;
      if (addr_seen !== ea) bad_a++;
      if (busy_c1 !== 1'b1) bad_b++;
    end
    n_checks++;
    if (dones != 3)
      $display("FAIL b2b_dones got=%0d want=3", dones);
    else n_pass++;
    n_checks++;
    if (bad_n != 0)
      $display("FAIL b2b_xfers bad_blits=%0d want=0", bad_n);
    else n_pass++;
    n_checks++;
    if (bad_a != 0)
      $display("FAIL b2b_addr bad_blits=%0d want=0", bad_a);
    else n_pass++;
    n_checks++;
    if (bad_b != 0)
      $display("FAIL b2b_busy bad_blits=%0d want=0", bad_b);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_full_blit();
    test_random_ready();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Reads the 66-row × 59-column ring sprite ROM one row at a time and streams one pixel per handshake to the framebuffer writer.
- Each pixel carries its screen coordinate and on/off bit.
- A single start command blits one whole sprite at (start_x, start_y).
- Sits between the game logic (sprite placement) and the framebuffer write port.

Parameters:
- ROWS, 66, sprite height; ROM address range 0..ROWS-1.
- COLS, 59, sprite width; ROM data width.
- ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= ROWS.
- X_W, 10, screen x coordinate width.
- Y_W, 10, screen y coordinate width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- start  in  1  one-cycle request to blit; accepted only in IDLE
- start_x  in  X_W  sprite left column; sampled when start is accepted
- start_y  in  Y_W  sprite top row; sampled when start is accepted
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last pixel is accepted
- rom_addr  out  ADDR_W  row address to the sprite ROM; registered
- rom_data  in  COLS  ROM row; bit COLS-1 is the leftmost pixel
- pix_valid  out  1  pixel output valid
- pix_ready  in  1  framebuffer accepts the pixel
- pix_x  out  X_W  pixel screen x
- pix_y  out  Y_W  pixel screen y
- pix_on  out  1  sprite bit for this pixel

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, done, pix_valid, pix_on = 0.
  - rom_addr, pix_x, pix_y = 0.
  - Row and column counters = 0.
  - Reset mid-blit abandons the sprite with no done pulse.
- States: IDLE, FETCH, LOAD, EMIT, FINISH.
- IDLE:
  - On start: latch start_x/start_y, row=0, go to FETCH.
  - start in any other state is ignored; it is not queued.
- FETCH (1 cycle): rom_addr <= row. ROM read latency is budgeted as one cycle.
- LOAD (1 cycle):
  - Capture rom_data into the COLS-bit row shift register.
  - col=0; pix_x=start_x; pix_y=start_y+row.
  - Assert pix_valid, with pix_on = captured bit COLS-1.
  - Go to EMIT.
- EMIT:
  - Transfer occurs when pix_valid && pix_ready.
  - While pix_ready=0, pix_x, pix_y and pix_on are held stable.
  - On a transfer with col<COLS-1: shift left, col+1, pix_x+1, pix_valid stays 1. Zero bubbles, so one pixel per cycle when pix_ready is held high.
  - On a transfer with col=COLS-1 and row<ROWS-1: pix_valid=0, row+1, go to FETCH.
  - On a transfer with col=COLS-1 and row=ROWS-1: pix_valid=0, go to FINISH.
- FINISH (1 cycle): done=1, busy=0, go to IDLE.
  - start in the FINISH cycle is ignored.
  - start in the following IDLE cycle is accepted.
- Arithmetic:
  - pix_x = start_x + col, modulo 2^X_W.
  - pix_y = start_y + row, modulo 2^Y_W.
  - Wrap-around is passed through; clipping is the framebuffer's job.
- Every pixel is emitted, including zero bits (pix_on=0), so the sprite overwrites its bounding box.
- Throughput with pix_ready=1 throughout:
  - ROWS*(COLS+2) cycles from the first FETCH to the last transfer, i.e. 4026 cycles.
  - done follows on the next cycle.
- busy=1 in FETCH, LOAD and EMIT; busy=0 in IDLE and FINISH.

Decomposition:
- Shared package blit_pkg:
  - state enum (IDLE, FETCH, LOAD, EMIT, FINISH).
  - Sprite geometry constants ROWS=66, COLS=59, ADDR_W=7.
  - Screen width constants X_W and Y_W.
- One natural sub-module, sprite_row_shifter:
  - Loads a COLS-bit row and presents the MSB.
  - Shifts on advance.
  - Flags the last column.
- The FSM and coordinate counters stay in sprite_blitter.
- The ROM is instantiated outside the block; the bench ties in the real ring ROM.

Test Plan:
- Reset, then start with start_x=100, start_y=20 and pix_ready=1:
  - First row: pix_on=1 exactly at x=126..132, y=20.
  - Row 17: pix_on=1 at x=100,101,157,158, y=37.
  - 66*59=3894 transfers in total.
  - done pulses once, 4027 cycles after start.
- Random pix_ready (50% duty):
  - Pixel sequence and coordinates are identical to the previous test.
  - pix_x/pix_y/pix_on never change while pix_valid=1 and pix_ready=0.
- Wrap: start_x=1000, start_y=1020:
  - Row 0 on-pixels at x=2..8 (mod 1024), y=1020.
  - Row 4 emitted with y=0.
- start pulsed during EMIT with different coordinates:
  - Ignored; the blit completes with the original coordinates.
  - A start 1 cycle after done is accepted, with busy=1 on the next cycle.
- rst_n asserted mid-row (row 30, col 10):
  - All outputs are 0 immediately, with no done pulse.
  - A new start after release begins at rom_addr=0.
- Back-to-back: start issued in the first IDLE cycle after done, 3 times:
  - Exactly 3 done pulses.
  - 3894 transfers per blit; rom_addr sweeps 0..65 for each blit.
